// File: rtl/btn_debounce_bank_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
//   Shared definitions for the push-button conditioning bank.
//   - Button index constants (bit positions within btn_in / btn_level / btn_pulse)
//   - rep_state_t: per-channel auto-repeat state (used only when BTN_REPEAT_EN
//     is defined)
//   - cnt_width(): bit width needed for a counter that runs 0..n-1
// -----------------------------------------------------------------------------
package btn_pkg;

    localparam int BTN_U = 3;
    localparam int BTN_D = 2;
    localparam int BTN_L = 1;
    localparam int BTN_R = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce_bank_if.sv
// -----------------------------------------------------------------------------
// btn_debounce_bank_if
//   Button bus between the raw-button source and the conditioning bank.
//   Signals:
//     btn_in     raw asynchronous buttons (bit3=U bit2=D bit1=L bit0=R)
//     btn_level  debounced level per button
//     btn_pulse  one-clk press pulse per button
//   Modports:
//     master  drives btn_in, observes the conditioned outputs
//     slave   the debounce bank
// -----------------------------------------------------------------------------
interface btn_debounce_bank_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;

    modport master (output btn_in,  input  btn_level, input  btn_pulse);
    modport slave  (input  btn_in,  output btn_level, output btn_pulse);
endinterface

// File: rtl/btn_debounce_bank_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
//   One button channel: 2-FF synchroniser, DB_SAMPLES-deep sample shift
//   register clocked by the shared tick, debounced level and registered
//   press pulse.
//   Optional feature (macro BTN_REPEAT_EN): IDLE/HELD/REPEAT auto-repeat FSM
//   that adds tick-aligned pulses while the button stays held. Without the
//   macro exactly one pulse is produced per debounced press.
// Ports:
//   clk      system clock
//   rst      asynchronous reset, active-low
//   i_tick   shared one-clk sample strobe
//   i_btn    raw asynchronous button
//   o_level  debounced level
//   o_pulse  one-clk pulse, coincident with the level's first high clk
// Requires DB_SAMPLES >= 2.
// -----------------------------------------------------------------------------
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DB_SAMPLES         = 8
`ifdef BTN_REPEAT_EN
   ,parameter int REPEAT_DELAY_TICKS = 500
   ,parameter int REPEAT_RATE_TICKS  = 100
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse
);

    logic [1:0]            r_sync;
    logic [DB_SAMPLES-1:0] r_shift;
    logic                  r_level;
    logic                  r_pulse;

    logic w_all_ones;
    logic w_all_zeros;
    logic w_rise;
    logic w_pulse_next;

    // The level decision looks at the samples already held, so the tick that
    // qualifies the level is the one after the DB_SAMPLES-th equal sample.
    assign w_all_ones  = &r_shift;
    assign w_all_zeros = ~|r_shift;
    assign w_rise      = i_tick & w_all_ones & ~r_level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync  <= '0;
            r_shift <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_pulse <= w_pulse_next;
            if (i_tick) begin
                r_shift <= {r_shift[DB_SAMPLES-2:0], r_sync[1]};
                if (w_all_ones) begin
                    r_level <= 1'b1;
                end else if (w_all_zeros) begin
                    r_level <= 1'b0;
                end
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int RC_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                            REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
    localparam int RC_W   = cnt_width(RC_MAX);

    rep_state_t      r_state;
    rep_state_t      w_state_next;
    logic [RC_W-1:0] r_rc;
    logic [RC_W-1:0] w_rc_next;
    logic            w_fall;

    assign w_fall = i_tick & w_all_zeros & r_level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_rc    <= '0;
        end else begin
            r_state <= w_state_next;
            r_rc    <= w_rc_next;
        end
    end

    // rc counts ticks since the last pulse; a release always wins over a
    // repeat that would land on the same tick.
    always_comb begin
        w_state_next = r_state;
        w_rc_next    = r_rc;
        w_pulse_next = 1'b0;
        if (w_fall) begin
            w_state_next = IDLE;
            w_rc_next    = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        w_state_next = HELD;
                        w_rc_next    = '0;
                        w_pulse_next = 1'b1;
                    end
                end
                HELD: begin
                    if (i_tick) begin
                        if (r_rc == RC_W'(REPEAT_DELAY_TICKS - 1)) begin
                            w_state_next = REPEAT;
                            w_rc_next    = '0;
                            w_pulse_next = 1'b1;
                        end else begin
                            w_rc_next = r_rc + RC_W'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (i_tick) begin
                        if (r_rc == RC_W'(REPEAT_RATE_TICKS - 1)) begin
                            w_rc_next    = '0;
                            w_pulse_next = 1'b1;
                        end else begin
                            w_rc_next = r_rc + RC_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_rc_next    = '0;
                end
            endcase
        end
    end
`else
    assign w_pulse_next = w_rise;
`endif

    assign o_level = r_level;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/btn_debounce_bank.sv
// -----------------------------------------------------------------------------
// btn_debounce_bank
//   Conditions N_BTN raw push-buttons for the watch/stopwatch top. A single
//   free-running tick generator (period CLK_HZ/SAMPLE_HZ clk) is shared by all
//   channels; each channel synchronises, debounces and edge-detects its bit.
//   btn_pulse drives btnU/btnD/btnL/btnR of top_watch_stopwatch.
//   Optional feature (macro BTN_REPEAT_EN): per-channel auto-repeat with
//   REPEAT_DELAY_TICKS / REPEAT_RATE_TICKS parameters.
// Ports:
//   clk   system clock
//   rst   asynchronous reset, active-low
//   bus   btn_debounce_bank_if.slave: btn_in (raw), btn_level, btn_pulse
// -----------------------------------------------------------------------------
module btn_debounce_bank
    import btn_pkg::*;
#(
    parameter int N_BTN              = 4,
    parameter int CLK_HZ             = 100_000_000,
    parameter int SAMPLE_HZ          = 1_000,
    parameter int DB_SAMPLES         = 8
`ifdef BTN_REPEAT_EN
   ,parameter int REPEAT_DELAY_TICKS = 500
   ,parameter int REPEAT_RATE_TICKS  = 100
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    btn_debounce_bank_if.slave    bus
);

    localparam int TICK_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int TICK_W   = cnt_width(TICK_DIV);

    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;
    logic [N_BTN-1:0]  w_level;
    logic [N_BTN-1:0]  w_pulse;

    assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
            btn_debounce_ch #(
                .DB_SAMPLES         (DB_SAMPLES)
`ifdef BTN_REPEAT_EN
               ,.REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS)
               ,.REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS)
`endif
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .i_tick  (w_tick),
                .i_btn   (bus.btn_in[gi]),
                .o_level (w_level[gi]),
                .o_pulse (w_pulse[gi])
            );
        end
    endgenerate

    assign bus.btn_level = w_level;
    assign bus.btn_pulse = w_pulse;

endmodule

// File: tb/tb_btn_debounce_bank.sv
module tb_btn_debounce_bank;
    import btn_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btn_debounce_bank_if #(.N_BTN(4)) bus();

    btn_debounce_bank #(
        .N_BTN      (4),
        .CLK_HZ     (1000),
        .SAMPLE_HZ  (100),
        .DB_SAMPLES (8)
`ifdef BTN_REPEAT_EN
       ,.REPEAT_DELAY_TICKS (20)
       ,.REPEAT_RATE_TICKS  (5)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Pulse monitor: counts pulses per bit and flags malformed pulses.
    int         pulse_cnt [4] = '{default: 0};
    int         pulse_bad     = 0;
    logic [3:0] prev_level    = '0;
    logic [3:0] prev_pulse    = '0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.btn_pulse[i]) begin
                pulse_cnt[i] <= pulse_cnt[i] + 1;
                if (prev_pulse[i]) pulse_bad <= pulse_bad + 1;
`ifndef BTN_REPEAT_EN
                if (!(bus.btn_level[i] && !prev_level[i])) pulse_bad <= pulse_bad + 1;
`endif
            end
        end
        prev_level <= bus.btn_level;
        prev_pulse <= bus.btn_pulse;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits (bounded) until btn_level[idx] equals val; n = negedges waited.
    task automatic wait_level(input int idx, input logic val, input int max_cyc, output int n);
        n = 0;
        while (n < max_cyc && bus.btn_level[idx] !== val) begin
            @(negedge clk);
            n++;
        end
    endtask

    int base [4];
    int lat;
    int hits;
    int n;
`ifdef BTN_REPEAT_EN
    int offs [$];
    int exp_offs [10] = '{0, 200, 250, 300, 350, 400, 450, 500, 550, 600};
`endif

    initial begin
        // Reset
        rst        = 1'b0;
        bus.btn_in = '0;
        wait_clk(3);
        check_val("rst_level", 32'(bus.btn_level), 0);
        check_val("rst_pulse", 32'(bus.btn_pulse), 0);
        $display("[TB] reset: level=%b pulse=%b", bus.btn_level, bus.btn_pulse);
        rst = 1'b1;
        wait_clk(5);

        // 1. Clean press on U
        base = pulse_cnt;
        bus.btn_in[BTN_U] = 1'b1;
        wait_level(BTN_U, 1'b1, 120, lat);
        $display("[TB] t1 clean press U: level after %0d clk", lat);
        check_val("t1_latency_82_92", 32'(lat >= 82 && lat <= 92), 1);
        wait_clk(200 - lat);
        check_val("t1_pulse_u", pulse_cnt[BTN_U] - base[BTN_U], 1);
        check_val("t1_others_no_pulse",
                  (pulse_cnt[2] - base[2]) + (pulse_cnt[1] - base[1]) + (pulse_cnt[0] - base[0]), 0);
        check_val("t1_others_level", 32'(bus.btn_level[2:0]), 0);
        bus.btn_in[BTN_U] = 1'b0;
        wait_level(BTN_U, 1'b0, 120, lat);
        wait_clk(20);
        $display("[TB] t1 release U: level low after %0d clk", lat);
        check_val("t1_release_level", 32'(bus.btn_level[BTN_U]), 0);
        check_val("t1_release_no_pulse", pulse_cnt[BTN_U] - base[BTN_U], 1);

        // 2. Bounce on L, then settle high
        base = pulse_cnt;
        hits = 0;
        for (int k = 0; k < 20; k++) begin
            bus.btn_in[BTN_L] = (k % 2 == 0);
            repeat (3) begin
                @(negedge clk);
                if (bus.btn_level[BTN_L]) hits++;
            end
        end
        check_val("t2_bounce_level", hits, 0);
        check_val("t2_bounce_no_pulse", pulse_cnt[BTN_L] - base[BTN_L], 0);
        bus.btn_in[BTN_L] = 1'b1;
        wait_level(BTN_L, 1'b1, 120, lat);
        $display("[TB] t2 bounce L: level after settle %0d clk", lat);
        check_val("t2_settle_latency", 32'(lat >= 70 && lat <= 95), 1);
        wait_clk(30);
        check_val("t2_one_pulse", pulse_cnt[BTN_L] - base[BTN_L], 1);
        bus.btn_in[BTN_L] = 1'b0;
        wait_level(BTN_L, 1'b0, 120, lat);

        // 3. Short dropout on R
        base = pulse_cnt;
        bus.btn_in[BTN_R] = 1'b1;
        wait_level(BTN_R, 1'b1, 120, lat);
        check_val("t3_level_up", 32'(bus.btn_level[BTN_R]), 1);
        hits = 0;
        bus.btn_in[BTN_R] = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (!bus.btn_level[BTN_R]) hits++;
        end
        bus.btn_in[BTN_R] = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (!bus.btn_level[BTN_R]) hits++;
        end
        $display("[TB] t3 dropout R: level-low samples %0d", hits);
        check_val("t3_level_held", hits, 0);
        check_val("t3_no_second_pulse", pulse_cnt[BTN_R] - base[BTN_R], 1);
        bus.btn_in[BTN_R] = 1'b0;
        wait_level(BTN_R, 1'b0, 120, lat);

        // 4. Simultaneous press U + D
        base = pulse_cnt;
        bus.btn_in[BTN_U] = 1'b1;
        bus.btn_in[BTN_D] = 1'b1;
        n = 0;
        while (n < 120 && bus.btn_pulse[3:2] == 2'b00) begin
            @(negedge clk);
            n++;
        end
        $display("[TB] t4 simultaneous U+D: pulses=%b after %0d clk", bus.btn_pulse[3:2], n);
        check_val("t4_same_clk", 32'(bus.btn_pulse[3:2]), 3);
        wait_clk(20);
        check_val("t4_pulse_u", pulse_cnt[BTN_U] - base[BTN_U], 1);
        check_val("t4_pulse_d", pulse_cnt[BTN_D] - base[BTN_D], 1);

        // 5. Async reset mid-hold, button still held on release
        check_val("t5_pre_level", 32'(bus.btn_level[3:2]), 3);
        #2;
        rst = 1'b0;
        #1;
        check_val("t5_async_level", 32'(bus.btn_level), 0);
        check_val("t5_async_pulse", 32'(bus.btn_pulse), 0);
        wait_clk(3);
        rst  = 1'b1;
        base = pulse_cnt;
        wait_level(BTN_U, 1'b1, 120, lat);
        $display("[TB] t5 reset mid-hold: level back after %0d clk", lat);
        check_val("t5_requal_latency", 32'(lat >= 82 && lat <= 92), 1);
        wait_clk(20);
        check_val("t5_pulse_u", pulse_cnt[BTN_U] - base[BTN_U], 1);
        check_val("t5_pulse_d", pulse_cnt[BTN_D] - base[BTN_D], 1);
        bus.btn_in[BTN_U] = 1'b0;
        bus.btn_in[BTN_D] = 1'b0;
        wait_level(BTN_U, 1'b0, 120, lat);
        wait_level(BTN_D, 1'b0, 120, lat);

        // 6. Long hold on R
`ifdef BTN_REPEAT_EN
        bus.btn_in[BTN_R] = 1'b1;
        n = 0;
        while (n < 120 && !bus.btn_pulse[BTN_R]) begin
            @(negedge clk);
            n++;
        end
        check_val("t6_first_pulse", 32'(bus.btn_pulse[BTN_R]), 1);
        offs.push_back(0);
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            if (bus.btn_pulse[BTN_R]) offs.push_back(k);
            if (k == 540) bus.btn_in[BTN_R] = 1'b0;
        end
        $display("[TB] t6 repeat R: %0d pulses", offs.size());
        check_val("t6_pulse_count", offs.size(), 10);
        for (int i = 0; i < 10; i++) begin
            check_val($sformatf("t6_pulse%0d_offset", i),
                      (i < offs.size()) ? offs[i] : -1, exp_offs[i]);
        end
        check_val("t6_level_low", 32'(bus.btn_level[BTN_R]), 0);
`else
        base = pulse_cnt;
        bus.btn_in[BTN_R] = 1'b1;
        wait_level(BTN_R, 1'b1, 120, lat);
        wait_clk(600);
        bus.btn_in[BTN_R] = 1'b0;
        wait_level(BTN_R, 1'b0, 120, lat);
        wait_clk(20);
        $display("[TB] t6 long hold R: %0d pulses", pulse_cnt[BTN_R] - base[BTN_R]);
        check_val("t6_single_pulse", pulse_cnt[BTN_R] - base[BTN_R], 1);
        check_val("t6_level_low", 32'(bus.btn_level[BTN_R]), 0);
`endif

        wait_clk(2);
        check_val("pulse_shape", pulse_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
